// File: rtl/mem_stage.sv
// Memory pipeline stage: issues loads/stores over a req/gnt/rvalid handshake,
// stalls upstream while an access is outstanding and feeds the MEM/WB register.
module mem_stage #(
   parameter int DW    = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_PCSrcM,
   input  logic             i_RegWriteM,
   input  logic             i_MemtoRegM,
   input  logic             i_MemWriteM,
   input  logic [DW-1:0]    i_ALUResultM,
   input  logic [DW-1:0]    i_WriteDataM,
   input  logic [3:0]       i_WA3M,
   output logic             o_mem_req,
   output logic             o_mem_we,
   output logic [DW-1:0]    o_mem_addr,
   output logic [DW-1:0]    o_mem_wdata,
   input  logic             i_mem_gnt,
   input  logic             i_mem_rvalid,
   input  logic [DW-1:0]    i_mem_rdata,
   output logic             o_stallM,
   output logic             o_PCSrcW,
   output logic             o_RegWriteW,
   output logic             o_MemtoRegW,
   output logic [DW-1:0]    o_ReadDataW,
   output logic [DW-1:0]    o_ALUOutW,
   output logic [3:0]       o_WA3W,
   output logic [CNT_W-1:0] o_stall_cnt
);

   typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

   state_t          r_state;
   state_t          w_nextState;
   logic            r_we;
   logic [DW-1:0]   r_addr;
   logic [DW-1:0]   r_wdata;
   logic            r_PCSrc;
   logic            r_RegWrite;
   logic            r_MemtoReg;
   logic [3:0]      r_WA3;
   logic [CNT_W-1:0] r_stallCnt;

   logic            w_isStore;
   logic            w_isLoad;
   logic            w_isMem;
   logic            w_commit;
   logic            w_commitFromIn;
   logic            w_latch;
   logic [DW-1:0]   w_readData;

   // A store wins over a load when both flags are set.
   assign w_isStore   = i_MemWriteM;
   assign w_isLoad    = ~i_MemWriteM & i_MemtoRegM;
   assign w_isMem     = w_isStore | w_isLoad;
   assign o_stall_cnt = r_stallCnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_nextState;
   end

   always_comb begin
      w_nextState    = r_state;
      o_mem_req      = 1'b0;
      o_mem_we       = 1'b0;
      o_mem_addr     = r_addr;
      o_mem_wdata    = r_wdata;
      o_stallM       = 1'b0;
      w_commit       = 1'b0;
      w_commitFromIn = 1'b0;
      w_latch        = 1'b0;
      w_readData     = '0;
      case (r_state)
         IDLE: begin
            o_mem_addr  = i_ALUResultM;
            o_mem_wdata = i_WriteDataM;
            o_mem_we    = w_isStore;
            if (!w_isMem) begin
               w_commit       = 1'b1;
               w_commitFromIn = 1'b1;
            end else begin
               o_mem_req = 1'b1;
               w_latch   = 1'b1;
               if (w_isStore && i_mem_gnt) begin
                  w_commit       = 1'b1;
                  w_commitFromIn = 1'b1;
               end else begin
                  o_stallM    = 1'b1;
                  w_nextState = (w_isLoad && i_mem_gnt) ? RSP : REQ;
               end
            end
         end
         REQ: begin
            o_mem_req = 1'b1;
            o_mem_we  = r_we;
            o_stallM  = 1'b1;
            if (i_mem_gnt) begin
               if (r_we) begin
                  o_stallM    = 1'b0;
                  w_commit    = 1'b1;
                  w_nextState = IDLE;
               end else begin
                  w_nextState = RSP;
               end
            end
         end
         RSP: begin
            o_stallM = 1'b1;
            if (i_mem_rvalid) begin
               o_stallM    = 1'b0;
               w_commit    = 1'b1;
               w_readData  = i_mem_rdata;
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Request fields and M controls are captured when a memory op is first seen,
   // so the handshake stays stable even though upstream keeps driving.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_PCSrc    <= 1'b0;
         r_RegWrite <= 1'b0;
         r_MemtoReg <= 1'b0;
         r_WA3      <= '0;
      end else if (w_latch) begin
         r_we       <= w_isStore;
         r_addr     <= i_ALUResultM;
         r_wdata    <= i_WriteDataM;
         r_PCSrc    <= i_PCSrcM;
         r_RegWrite <= i_RegWriteM;
         r_MemtoReg <= i_MemtoRegM;
         r_WA3      <= i_WA3M;
      end
   end

   // Non-commit edges insert a bubble: controls clear, data registers hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_PCSrcW    <= 1'b0;
         o_RegWriteW <= 1'b0;
         o_MemtoRegW <= 1'b0;
         o_ReadDataW <= '0;
         o_ALUOutW   <= '0;
         o_WA3W      <= '0;
      end else if (w_commit) begin
         o_PCSrcW    <= w_commitFromIn ? i_PCSrcM     : r_PCSrc;
         o_RegWriteW <= w_commitFromIn ? i_RegWriteM  : r_RegWrite;
         o_MemtoRegW <= w_commitFromIn ? i_MemtoRegM  : r_MemtoReg;
         o_ALUOutW   <= w_commitFromIn ? i_ALUResultM : r_addr;
         o_WA3W      <= w_commitFromIn ? i_WA3M       : r_WA3;
         o_ReadDataW <= w_readData;
      end else begin
         o_PCSrcW    <= 1'b0;
         o_RegWriteW <= 1'b0;
         o_MemtoRegW <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              r_stallCnt <= '0;
      else if (o_stallM && (r_stallCnt != '1)) r_stallCnt <= r_stallCnt + 1'b1;
   end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected writebacks are queued with their
// commit cycle when driven and popped whenever RegWriteW is observed.
module tb_mem_stage;

   logic        clk;
   logic        rst_n;
   logic        i_PCSrcM, i_RegWriteM, i_MemtoRegM, i_MemWriteM;
   logic [31:0] i_ALUResultM, i_WriteDataM;
   logic [3:0]  i_WA3M;
   logic        o_mem_req, o_mem_we;
   logic [31:0] o_mem_addr, o_mem_wdata;
   logic        i_mem_gnt, i_mem_rvalid;
   logic [31:0] i_mem_rdata;
   logic        o_stallM, o_PCSrcW, o_RegWriteW, o_MemtoRegW;
   logic [31:0] o_ReadDataW, o_ALUOutW;
   logic [3:0]  o_WA3W;
   logic [15:0] o_stall_cnt;

   typedef struct {
      int          cyc;
      logic        pc;
      logic        mtr;
      logic [31:0] rd;
      logic [31:0] alu;
      logic [3:0]  wa3;
   } wbExp_t;

   wbExp_t sbQ[$];
   int     nChecks = 0;
   int     nBad    = 0;
   int     cycleCnt = 0;

   mem_stage #(.DW(32), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_PCSrcM(i_PCSrcM), .i_RegWriteM(i_RegWriteM), .i_MemtoRegM(i_MemtoRegM),
      .i_MemWriteM(i_MemWriteM), .i_ALUResultM(i_ALUResultM), .i_WriteDataM(i_WriteDataM),
      .i_WA3M(i_WA3M), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
      .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_gnt(i_mem_gnt),
      .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata), .o_stallM(o_stallM),
      .o_PCSrcW(o_PCSrcW), .o_RegWriteW(o_RegWriteW), .o_MemtoRegW(o_MemtoRegW),
      .o_ReadDataW(o_ReadDataW), .o_ALUOutW(o_ALUOutW), .o_WA3W(o_WA3W),
      .o_stall_cnt(o_stall_cnt)
   );

   // Free-running clock and edge counter used to time expected commits.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nChecks++;
      if (observed !== expected) begin
         nBad++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic pc, input logic rw, input logic mtr, input logic mw,
                                input logic [31:0] alu, input logic [31:0] wd, input logic [3:0] wa3);
      i_PCSrcM     = pc;
      i_RegWriteM  = rw;
      i_MemtoRegM  = mtr;
      i_MemWriteM  = mw;
      i_ALUResultM = alu;
      i_WriteDataM = wd;
      i_WA3M       = wa3;
   endtask

   task automatic pushExp(input logic pc, input logic mtr, input logic [31:0] rd,
                          input logic [31:0] alu, input logic [3:0] wa3, input int lat);
      wbExp_t e;
      e.cyc = cycleCnt + lat;
      e.pc  = pc;
      e.mtr = mtr;
      e.rd  = rd;
      e.alu = alu;
      e.wa3 = wa3;
      sbQ.push_back(e);
   endtask

   // Every observed register write must match the oldest queued writeback,
   // including the edge on which it was expected to land.
   always @(negedge clk) begin
      if (rst_n && o_RegWriteW) begin
         if (sbQ.size() == 0) begin
            checkOutput("sbHasEntry", 32'(sbQ.size()), 32'd1);
         end else begin
            wbExp_t e;
            e = sbQ.pop_front();
            checkOutput("wbCycle", 32'(cycleCnt), 32'(e.cyc));
            checkOutput("wbPCSrc", 32'(o_PCSrcW), 32'(e.pc));
            checkOutput("wbMemtoReg", 32'(o_MemtoRegW), 32'(e.mtr));
            checkOutput("wbReadData", o_ReadDataW, e.rd);
            checkOutput("wbALUOut", o_ALUOutW, e.alu);
            checkOutput("wbWA3", 32'(o_WA3W), 32'(e.wa3));
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 4'd0);
      i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = 32'h0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("rstRegWriteW", 32'(o_RegWriteW), 32'd0);
      checkOutput("rstPCSrcW", 32'(o_PCSrcW), 32'd0);
      checkOutput("rstMemtoRegW", 32'(o_MemtoRegW), 32'd0);
      checkOutput("rstReadDataW", o_ReadDataW, 32'h0);
      checkOutput("rstALUOutW", o_ALUOutW, 32'h0);
      checkOutput("rstWA3W", 32'(o_WA3W), 32'd0);
      checkOutput("rstStallCnt", 32'(o_stall_cnt), 32'd0);
      checkOutput("rstReq", 32'(o_mem_req), 32'd0);
      checkOutput("rstStall", 32'(o_stallM), 32'd0);

      // Plain ALU op commits one edge later
      @(negedge clk);
      applyStimulus(0, 1, 0, 0, 32'h1234, 32'h0, 4'd5);
      pushExp(0, 0, 32'h0, 32'h1234, 4'd5, 1);
      #1;
      checkOutput("aluReq", 32'(o_mem_req), 32'd0);
      checkOutput("aluStall", 32'(o_stallM), 32'd0);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 4'd0);

      // Store granted in its first cycle
      @(negedge clk);
      applyStimulus(0, 0, 0, 1, 32'h40, 32'hDEADBEEF, 4'd0);
      i_mem_gnt = 1'b1;
      #1;
      checkOutput("stReq", 32'(o_mem_req), 32'd1);
      checkOutput("stWe", 32'(o_mem_we), 32'd1);
      checkOutput("stAddr", o_mem_addr, 32'h40);
      checkOutput("stWdata", o_mem_wdata, 32'hDEADBEEF);
      checkOutput("stStall", 32'(o_stallM), 32'd0);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 4'd0);
      i_mem_gnt = 1'b0;
      #1;
      checkOutput("stReqDrop", 32'(o_mem_req), 32'd0);
      checkOutput("stStallCnt", 32'(o_stall_cnt), 32'd0);
      checkOutput("stALUOutW", o_ALUOutW, 32'h40);
      checkOutput("stRegWriteW", 32'(o_RegWriteW), 32'd0);

      // Load: grant after 2 cycles, data 3 cycles after grant
      @(negedge clk);
      applyStimulus(0, 1, 1, 0, 32'h80, 32'h0, 4'd7);
      pushExp(0, 1, 32'hCAFEF00D, 32'h80, 4'd7, 6);
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         i_mem_gnt    = (i == 2);
         i_mem_rvalid = (i == 5);
         i_mem_rdata  = (i == 5) ? 32'hCAFEF00D : 32'h0;
         #1;
         checkOutput("ldReq", 32'(o_mem_req), 32'(i <= 2));
         if (i <= 2) checkOutput("ldAddr", o_mem_addr, 32'h80);
         checkOutput("ldStall", 32'(o_stallM), 32'(i < 5));
         if (i > 0) checkOutput("ldBubble", 32'(o_RegWriteW), 32'd0);
      end

      // ALU op right behind the load
      @(negedge clk);
      applyStimulus(1, 1, 0, 0, 32'h5678, 32'h0, 4'd6);
      i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = 32'h0;
      pushExp(1, 0, 32'h0, 32'h5678, 4'd6, 1);
      #1;
      checkOutput("ldStallCnt", 32'(o_stall_cnt), 32'd5);
      checkOutput("ldReadDataW", o_ReadDataW, 32'hCAFEF00D);
      checkOutput("b2bStall", 32'(o_stallM), 32'd0);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 4'd0);

      // Store+load flags together, granted one cycle late
      @(negedge clk);
      applyStimulus(0, 1, 1, 1, 32'h44, 32'h11, 4'd2);
      pushExp(0, 1, 32'h0, 32'h44, 4'd2, 2);
      #1;
      checkOutput("bothWe", 32'(o_mem_we), 32'd1);
      checkOutput("bothStall", 32'(o_stallM), 32'd1);
      @(negedge clk);
      i_mem_gnt = 1'b1;
      #1;
      checkOutput("bothReqAddr", o_mem_addr, 32'h44);
      checkOutput("bothReqWdata", o_mem_wdata, 32'h11);
      checkOutput("bothGntStall", 32'(o_stallM), 32'd0);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 4'd0);
      i_mem_gnt = 1'b0;
      #1;
      checkOutput("bothStallCnt", 32'(o_stall_cnt), 32'd6);

      // Reset while waiting for load data, then a stray rvalid
      @(negedge clk);
      applyStimulus(0, 1, 1, 0, 32'h100, 32'h0, 4'd9);
      i_mem_gnt = 1'b1;
      @(negedge clk);
      i_mem_gnt = 1'b0;
      #1;
      checkOutput("rspReq", 32'(o_mem_req), 32'd0);
      checkOutput("rspStall", 32'(o_stallM), 32'd1);
      #2;
      rst_n = 1'b0;
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 4'd0);
      #1;
      checkOutput("midRstStall", 32'(o_stallM), 32'd0);
      checkOutput("midRstCnt", 32'(o_stall_cnt), 32'd0);
      checkOutput("midRstALUOutW", o_ALUOutW, 32'h0);
      checkOutput("midRstReadDataW", o_ReadDataW, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 32'h55555555;
      #1;
      checkOutput("lateRvStall", 32'(o_stallM), 32'd0);
      checkOutput("lateRvReq", 32'(o_mem_req), 32'd0);
      @(negedge clk);
      i_mem_rvalid = 1'b0;
      #1;
      checkOutput("lateRvReadDataW", o_ReadDataW, 32'h0);
      checkOutput("lateRvRegWriteW", 32'(o_RegWriteW), 32'd0);
      applyStimulus(1, 1, 0, 0, 32'hABC, 32'h0, 4'd3);
      pushExp(1, 0, 32'h0, 32'hABC, 4'd3, 1);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 4'd0);

      // Saturating stall counter under a never-granted load
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      applyStimulus(0, 1, 1, 0, 32'h200, 32'h0, 4'd1);
      repeat (65534) @(negedge clk);
      #1;
      checkOutput("satNear", 32'(o_stall_cnt), 32'h0000FFFE);
      checkOutput("satAddr", o_mem_addr, 32'h200);
      checkOutput("satReq", 32'(o_mem_req), 32'd1);
      repeat (4) @(negedge clk);
      #1;
      checkOutput("satFull", 32'(o_stall_cnt), 32'h0000FFFF);

      rst_n = 1'b0;
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 4'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("sbDrained", 32'(sbQ.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", nChecks, nBad);
      $finish;
   end

endmodule
